// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

    typedef enum logic {
        REGISTERED  = 1'b0,
        FALLTHROUGH = 1'b1
    } fwft_mode_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake, data and status bundle between a FIFO and its producer/consumer.
interface sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic                        w;
    logic                        r;
    logic [WIDTH-1:0]            data_in;
    logic                        err_clr;
    logic [WIDTH-1:0]            data_out;
    logic                        rd_valid;
    logic                        full;
    logic                        empty;
    logic                        almost_full;
    logic                        almost_empty;
    logic [cnt_width(DEPTH)-1:0] count;
    logic                        overflow;
    logic                        underflow;

    modport master (
        output w, r, data_in, err_clr,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w, r, data_in, err_clr,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage array: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold flags,
// sticky overflow/underflow and optional first-word-fall-through read mode.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int         WIDTH    = 16,
    parameter int         DEPTH    = 4,
    parameter int         AF_LEVEL = DEPTH - 1,
    parameter int         AE_LEVEL = 1,
    parameter fwft_mode_e FWFT     = REGISTERED
) (
    input  logic       clk,
    input  logic       rst,
    sync_fifo_if.slave bus
);

    localparam int            CW       = cnt_width(DEPTH);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;
    logic [WIDTH-1:0] head_word;
    logic             full;
    logic             empty;
    logic             bypass;
    logic             wr_ok;
    logic             rd_ok;
    logic             ovf_set;
    logic             unf_set;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        bypass  = (FWFT == REGISTERED) && bus.w && bus.r && empty;
        rd_ok   = bus.r && !empty;
        wr_ok   = bus.w && !bypass && (!full || bus.r);
        ovf_set = bus.w && !bus.r && full;
        unf_set = bus.r && !bus.w && empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A fresh error in the same cycle as err_clr keeps the flag set.
            overflow_q  <= ovf_set | (overflow_q & ~bus.err_clr);
            underflow_q <= unf_set | (underflow_q & ~bus.err_clr);
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_addr (rd_ptr),
        .rd_data (head_word)
    );

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    generate
        if (FWFT == REGISTERED) begin : g_registered
            logic [WIDTH-1:0] dout_q;
            logic             rv_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                    rv_q   <= 1'b0;
                end else begin
                    rv_q <= rd_ok | bypass;
                    if (rd_ok) begin
                        dout_q <= head_word;
                    end else if (bypass) begin
                        dout_q <= bus.data_in;
                    end
                end
            end

            assign bus.data_out = dout_q;
            assign bus.rd_valid = rv_q;
        end else begin : g_fallthrough
            assign bus.data_out = empty ? '0 : head_word;
            assign bus.rd_valid = !empty;
        end
    endgenerate

endmodule
